alu_execute_stage: RTL and testbench

//  Execute stage directly downstream of the ALU control decoder. Accepts the 4-bit

---
 rtl/alu_execute_stage.sv | 105 ++++++++++
 tb/tb_alu_execute_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_execute_stage.sv
// ALU execute stage: registered result (M) plus a one-entry skid buffer (S) behind a valid/ready handshake.
// Optional feature: define ALU_NOR_EN to make op code 1100 a legal NOR.
module alu_execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             illegal_op
);

  logic             m_valid;
  logic [WIDTH-1:0] m_result;
  logic             m_zero;
  logic             m_illegal;

  logic             s_valid;
  logic [WIDTH-1:0] s_result;
  logic             s_zero;
  logic             s_illegal;

  logic [WIDTH-1:0] alu_next;
  logic             zero_next;
  logic             illegal_next;
  logic             accept;
  logic             m_free;

  always_comb begin
    alu_next     = '0;
    illegal_next = 1'b0;
    case (operation)
      4'b0000: alu_next = src_a & src_b;
      4'b0001: alu_next = src_a | src_b;
      4'b0010: alu_next = src_a + src_b;
      4'b0110: alu_next = src_a - src_b;
      4'b0111: alu_next = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`ifdef ALU_NOR_EN
      4'b1100: alu_next = ~(src_a | src_b);
`endif
      default: begin
        alu_next     = '0;
        illegal_next = 1'b1;
      end
    endcase
  end

  assign zero_next = (alu_next == '0);

  // in_ready comes straight from a flop, so it never sees out_ready combinationally.
  assign in_ready = !s_valid;
  assign accept   = in_valid && in_ready;
  assign m_free   = !m_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid   <= 1'b0;
      m_result  <= '0;
      m_zero    <= 1'b0;
      m_illegal <= 1'b0;
      s_valid   <= 1'b0;
      s_result  <= '0;
      s_zero    <= 1'b0;
      s_illegal <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_free) begin
      // S is older than anything at the input, and in_ready is low whenever S is full.
      if (s_valid) begin
        m_valid   <= 1'b1;
        m_result  <= s_result;
        m_zero    <= s_zero;
        m_illegal <= s_illegal;
        s_valid   <= 1'b0;
      end else if (accept) begin
        m_valid   <= 1'b1;
        m_result  <= alu_next;
        m_zero    <= zero_next;
        m_illegal <= illegal_next;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_valid   <= 1'b1;
      s_result  <= alu_next;
      s_zero    <= zero_next;
      s_illegal <= illegal_next;
    end
  end

  assign out_valid  = m_valid;
  assign alu_result = m_result;
  assign zero       = m_zero;
  assign illegal_op = m_illegal;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed self-checking bench for alu_execute_stage (WIDTH=32); honours ALU_NOR_EN when defined.
module tb_alu_execute_stage;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       operation;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             illegal_op;

  int assertCount = 0;
  int failCount   = 0;

  alu_execute_stage #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operation  (operation),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid  = 1'b1;
    operation = op;
    src_a     = a;
    src_b     = b;
  endtask

  task automatic sendOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(op, a, b);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    operation = 4'b0000;
    src_a     = '0;
    src_b     = '0;
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_result", alu_result, 32'h0);
    checkOutput("rst_zero", {31'b0, zero}, 32'd0);
    checkOutput("rst_illegal", {31'b0, illegal_op}, 32'd0);
    reset = 1'b0;

    sendOp(4'b0010, 32'h7FFF_FFFF, 32'h1);
    checkOutput("add_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("add_result", alu_result, 32'h8000_0000);
    checkOutput("add_zero", {31'b0, zero}, 32'd0);
    checkOutput("add_illegal", {31'b0, illegal_op}, 32'd0);
    sendOp(4'b0110, 32'd5, 32'd5);
    checkOutput("sub_result", alu_result, 32'h0);
    checkOutput("sub_zero", {31'b0, zero}, 32'd1);
    sendOp(4'b0010, 32'hFFFF_FFFF, 32'h2);
    checkOutput("add_wrap", alu_result, 32'h1);
    sendOp(4'b0110, 32'h0, 32'h1);
    checkOutput("sub_wrap", alu_result, 32'hFFFF_FFFF);

    sendOp(4'b0111, 32'hFFFF_FFFF, 32'h1);
    checkOutput("slt_neg_lt_pos", alu_result, 32'h1);
    sendOp(4'b0111, 32'h1, 32'hFFFF_FFFF);
    checkOutput("slt_pos_lt_neg", alu_result, 32'h0);
    checkOutput("slt_zero", {31'b0, zero}, 32'd1);
    sendOp(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    checkOutput("and_result", alu_result, 32'h0000_F000);
    sendOp(4'b0001, 32'h0000_F0F0, 32'h0000_FF00);
    checkOutput("or_result", alu_result, 32'h0000_FFF0);
    tick();
    checkOutput("idle_valid", {31'b0, out_valid}, 32'd0);

    // Continuous flow: one new result every cycle.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(4'b0010, i, 32'd100);
      tick();
      checkOutput("stream_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("stream_result", alu_result, 32'(100 + i));
    end
    in_valid = 1'b0;
    tick();

    out_ready = 1'b0;
    sendOp(4'b0010, 32'd10, 32'd20);
    checkOutput("bp_x_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("bp_x_ready", {31'b0, in_ready}, 32'd1);
    sendOp(4'b0110, 32'd100, 32'd1);
    checkOutput("bp_full_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("bp_hold_x", alu_result, 32'd30);
    applyStimulus(4'b0001, 32'h5555_0000, 32'h0000_5555);
    tick();
    checkOutput("bp_stable_x", alu_result, 32'd30);
    checkOutput("bp_still_full", {31'b0, in_ready}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bp_y_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("bp_y_result", alu_result, 32'd99);
    checkOutput("bp_y_ready", {31'b0, in_ready}, 32'd1);
    tick();
    checkOutput("bp_drained", {31'b0, out_valid}, 32'd0);

    out_ready = 1'b0;
    sendOp(4'b0000, 32'hFFFF_FFFF, 32'h1234_5678);
    sendOp(4'b0001, 32'h1, 32'h2);
    checkOutput("fl_full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    applyStimulus(4'b0010, 32'd7, 32'd8);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("fl_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("fl_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("fl_nothing_after", {31'b0, out_valid}, 32'd0);
    end

    out_ready = 1'b0;
    sendOp(4'b0010, 32'd1, 32'd1);
    sendOp(4'b0010, 32'd2, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_mid_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_mid_result", alu_result, 32'h0);
    out_ready = 1'b1;
    tick();
    checkOutput("rst_mid_empty", {31'b0, out_valid}, 32'd0);

    sendOp(4'b1100, 32'h0, 32'h0);
    checkOutput("nor_valid", {31'b0, out_valid}, 32'd1);
`ifdef ALU_NOR_EN
    checkOutput("nor_result", alu_result, 32'hFFFF_FFFF);
    checkOutput("nor_illegal", {31'b0, illegal_op}, 32'd0);
    checkOutput("nor_zero", {31'b0, zero}, 32'd0);
`else
    checkOutput("nor_result", alu_result, 32'h0);
    checkOutput("nor_illegal", {31'b0, illegal_op}, 32'd1);
    checkOutput("nor_zero", {31'b0, zero}, 32'd1);
`endif
    sendOp(4'b0101, 32'hDEAD_BEEF, 32'h1234_5678);
    checkOutput("ill_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("ill_result", alu_result, 32'h0);
    checkOutput("ill_zero", {31'b0, zero}, 32'd1);
    checkOutput("ill_flag", {31'b0, illegal_op}, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
